// File: rtl/i2c_reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_reg_bank_pkg                                                 |
// | Purpose  : Shared definitions for the I2C register bank. These include the  |
// |            FSM state encodings, the write-direction R/W bit value, the      |
// |            default device address and the register word width.             |
// | Ports    : none (package)                                                   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package i2c_reg_bank_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_PTR    = 3'd2,
    S_HBYTE  = 3'd3,
    S_LBYTE  = 3'd4,
    S_IGNORE = 3'd5
  } state_e;

  localparam logic       I2C_RW_WRITE        = 1'b0;
  localparam logic [6:0] I2C_DEFAULT_ADDRESS = 7'h42;
  localparam int         REG_W               = 16;

endpackage
`default_nettype wire

// File: rtl/i2c_reg_bank_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_reg_bank_ptr                                                 |
// | Purpose  : Register pointer with load, auto-increment and wrap at NUM_REGS.  |
// |            Also flags whether a candidate pointer byte is in range.        |
// | Ports    : clk, rst_n   clock / async active-low reset                      |
// |            load_en      load ptr from load_val[PTR_W-1:0]                   |
// |            load_val     candidate pointer byte                              |
// |            inc_en       advance ptr, wrapping NUM_REGS-1 -> 0               |
// |            ptr          current pointer                                     |
// |            ptr_ok       load_val addresses an existing register             |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module i2c_reg_bank_ptr #(
  parameter int NUM_REGS = 8,
  parameter int PTR_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [7:0]       load_val,
  input  logic             inc_en,
  output logic [PTR_W-1:0] ptr,
  output logic             ptr_ok
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Because NUM_REGS <= 2**PTR_W, a full-byte compare against NUM_REGS covers
  // both the "upper bits zero" and the "index below NUM_REGS" conditions.
  assign ptr_ok = ({24'd0, load_val} < 32'(NUM_REGS));

  always_comb begin
    ptr_d = ptr_q;
    if (load_en) begin
      ptr_d = load_val[PTR_W-1:0];
    end else if (inc_en) begin
      ptr_d = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/i2c_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_reg_bank                                                     |
// | Purpose  : Consumes the I2C slave byte stream. It decodes the device       |
// |            address, the register pointer and big-endian 16-bit words, and  |
// |            writes them into a bank of NUM_REGS registers with pointer      |
// |            auto-increment.                                                 |
// | Ports    : clk, rst_n   clock / async active-low reset                      |
// |            start, stop  1-cycle START (or repeated START) / STOP strobes    |
// |            wr           1-cycle byte-valid strobe, write_data = the byte    |
// |            regs         register bank, reg i at [16*i+15:16*i]              |
// |            update       1-cycle pulse when regs are written                 |
// |            busy         high from address match until STOP or START         |
// | Config   : I2C_REG_BANK_SHADOW_EN - words are staged in a shadow bank and   |
// |            published to regs all at once at STOP. When the macro is not    |
// |            defined, each word is written straight into regs.               |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module i2c_reg_bank
  import i2c_reg_bank_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = I2C_DEFAULT_ADDRESS,
  parameter int         NUM_REGS    = 8,
  parameter int         PTR_W       = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      wr,
  input  logic [7:0]                write_data,
  output logic [NUM_REGS*REG_W-1:0] regs,
  output logic                      update,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [7:0]          hi_q, hi_d;
  logic [NUM_REGS-1:0][REG_W-1:0] regs_q, regs_d;
  logic                update_q, update_d;

  logic                ptr_load;
  logic                ptr_inc;
  logic                ptr_ok;
  logic [PTR_W-1:0]    ptr;
  logic                commit;
  logic [REG_W-1:0]    word;

  assign word = {hi_q, write_data};

  i2c_reg_bank_ptr #(
    .NUM_REGS (NUM_REGS),
    .PTR_W    (PTR_W)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (ptr_load),
    .load_val (write_data),
    .inc_en   (ptr_inc),
    .ptr      (ptr),
    .ptr_ok   (ptr_ok)
  );

  // Protocol FSM: START beats STOP, and both of them beat a byte strobe. A byte
  // that arrives in the same cycle as START or STOP is therefore dropped.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    ptr_load = 1'b0;
    ptr_inc  = 1'b0;
    commit   = 1'b0;
    if (start) begin
      state_d = S_ADDR;
      busy_d  = 1'b0;
      hi_d    = '0;
    end else if (stop) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      hi_d    = '0;
    end else if (wr) begin
      case (state_q)
        S_ADDR: begin
          if (write_data[7:1] == I2C_ADDRESS && write_data[0] == I2C_RW_WRITE) begin
            state_d = S_PTR;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IGNORE;
          end
        end
        S_PTR: begin
          if (ptr_ok) begin
            ptr_load = 1'b1;
            state_d  = S_HBYTE;
          end else begin
            state_d  = S_IGNORE;
          end
        end
        S_HBYTE: begin
          hi_d    = write_data;
          state_d = S_LBYTE;
        end
        S_LBYTE: begin
          commit  = 1'b1;
          ptr_inc = 1'b1;
          state_d = S_HBYTE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

`ifdef I2C_REG_BANK_SHADOW_EN
  logic [NUM_REGS-1:0][REG_W-1:0] shadow_q, shadow_d;
  logic [NUM_REGS-1:0]            dirty_q, dirty_d;
  logic                           publish;

  // STOP publishes the words that are pending. A START that arrives in the
  // same cycle wins, so the pending data is held until a later STOP.
  assign publish = stop && !start;

  always_comb begin
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    regs_d   = regs_q;
    update_d = 1'b0;
    if (commit) begin
      shadow_d[ptr] = word;
      dirty_d[ptr]  = 1'b1;
    end
    if (publish) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dirty_q[i]) begin
          regs_d[i] = shadow_q[i];
        end
      end
      update_d = |dirty_q;
      dirty_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      dirty_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end
`else
  always_comb begin
    regs_d   = regs_q;
    update_d = commit;
    if (commit) begin
      regs_d[ptr] = word;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      regs_q   <= '0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      regs_q   <= regs_d;
      update_q <= update_d;
    end
  end

  assign regs   = regs_q;
  assign update = update_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2c_reg_bank                                                  |
// | Purpose  : Self-checking bench for i2c_reg_bank. A transaction-level model  |
// |            (byte counting per transaction) predicts regs/update/busy every  |
// |            cycle; literal checks pin the model on the directed scenarios.   |
// | Config   : honours I2C_REG_BANK_SHADOW_EN like the design                   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_i2c_reg_bank;

  localparam int         NUM_REGS = 8;
  localparam logic [7:0] ADDR_WR  = 8'h84;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic                     stop = 1'b0;
  logic                     wr = 1'b0;
  logic [7:0]               write_data = 8'h00;
  logic [NUM_REGS*16-1:0]   regs;
  logic                     update;
  logic                     busy;

  int checks = 0;
  int passed = 0;
  int upd_cnt = 0;

  i2c_reg_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .wr         (wr),
    .write_data (write_data),
    .regs       (regs),
    .update     (update),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [NUM_REGS];
  logic [15:0] m_shadow [NUM_REGS];
  logic        m_dirty [NUM_REGS];
  logic        m_update, m_busy, in_txn, addr_ok, ptr_ok;
  logic [7:0]  hi;
  int          nb, base;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        m_regs[i] <= '0; m_shadow[i] <= '0; m_dirty[i] <= 1'b0;
      end
      m_update <= 1'b0; m_busy <= 1'b0; in_txn <= 1'b0;
      addr_ok <= 1'b0; ptr_ok <= 1'b0; hi <= '0; nb <= 0; base <= 0;
    end else begin
      m_update <= 1'b0;
      if (start) begin
        in_txn <= 1'b1; nb <= 0; addr_ok <= 1'b0; ptr_ok <= 1'b0; m_busy <= 1'b0;
      end else if (stop) begin
        in_txn <= 1'b0; addr_ok <= 1'b0; ptr_ok <= 1'b0; m_busy <= 1'b0;
`ifdef I2C_REG_BANK_SHADOW_EN
        for (int i = 0; i < NUM_REGS; i++) begin
          if (m_dirty[i]) begin
            m_regs[i]  <= m_shadow[i];
            m_update   <= 1'b1;
          end
          m_dirty[i] <= 1'b0;
        end
`endif
      end else if (wr && in_txn) begin
        nb <= nb + 1;
        if (nb == 0) begin
          addr_ok <= (write_data == ADDR_WR);
          m_busy  <= (write_data == ADDR_WR);
        end else if (nb == 1) begin
          ptr_ok <= addr_ok && (int'(write_data) < NUM_REGS);
          base   <= int'(write_data);
        end else if (ptr_ok) begin
          if (((nb - 2) % 2) == 0) begin
            hi <= write_data;
          end else begin
`ifdef I2C_REG_BANK_SHADOW_EN
            m_shadow[(base + (nb - 3) / 2) % NUM_REGS] <= {hi, write_data};
            m_dirty[(base + (nb - 3) / 2) % NUM_REGS]  <= 1'b1;
`else
            m_regs[(base + (nb - 3) / 2) % NUM_REGS] <= {hi, write_data};
            m_update <= 1'b1;
`endif
          end
        end
      end
    end
  end

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[16*i +: 16] = m_regs[i];
    return v;
  endfunction

  function automatic logic [15:0] dut_reg(input int i);
    return regs[16*i +: 16];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("regs_vs_model", 128'(regs), model_vec());
    check("update_vs_model", 128'(update), 128'(m_update));
    check("busy_vs_model", 128'(busy), 128'(m_busy));
    if (update === 1'b1) upd_cnt++;
  end

  // ---------------- stimulus ----------------
  // Each call is entered 1 time unit after a posedge and returns at the same
  // phase one cycle later, with the strobes held for exactly that one cycle.
  task automatic drive(input logic s, input logic p, input logic w, input logic [7:0] d);
    start = s; stop = p; wr = w; write_data = d;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; wr = 1'b0;
  endtask

  task automatic do_start(); drive(1'b1, 1'b0, 1'b0, 8'h00); endtask
  task automatic do_stop();  drive(1'b0, 1'b1, 1'b0, 8'h00); endtask
  task automatic do_byte(input logic [7:0] b); drive(1'b0, 1'b0, 1'b1, b); endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int base_cnt;
    idle(2);
    check("reset_regs", 128'(regs), 128'd0);
    check("reset_busy_update", 128'({busy, update}), 128'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: single word
    base_cnt = upd_cnt;
    do_start(); do_byte(8'h84); do_byte(8'h02); do_byte(8'h12); do_byte(8'h34); do_stop();
    idle(2);
    check("t1_reg2", 128'(dut_reg(2)), 128'h1234);
    check("t1_others", 128'(regs & ~(128'hFFFF << 32)), 128'd0);
    check("t1_one_update", 128'(upd_cnt - base_cnt), 128'd1);

    // 2: burst with wrap
    do_start(); do_byte(8'h84); do_byte(8'h06);
    do_byte(8'hAA); do_byte(8'hBB); do_byte(8'hCC); do_byte(8'hDD); do_byte(8'hEE); do_byte(8'hFF);
    do_stop(); idle(2);
    check("t2_reg6", 128'(dut_reg(6)), 128'hAABB);
    check("t2_reg7", 128'(dut_reg(7)), 128'hCCDD);
    check("t2_reg0_wrap", 128'(dut_reg(0)), 128'hEEFF);

    // 3: wrong address and read bit
    base_cnt = upd_cnt;
    do_start(); do_byte(8'h86); do_byte(8'h01); do_byte(8'h12); do_byte(8'h34); do_stop();
    do_start(); do_byte(8'h85); do_byte(8'h01); do_byte(8'h56); do_byte(8'h78); do_stop();
    idle(2);
    check("t3_reg1", 128'(dut_reg(1)), 128'h0000);
    check("t3_no_update", 128'(upd_cnt - base_cnt), 128'd0);

    // 4: incomplete word, then out-of-range pointer
    base_cnt = upd_cnt;
    do_start(); do_byte(8'h84); do_byte(8'h03); do_byte(8'h55); do_stop();
    do_start(); do_byte(8'h84); do_byte(8'h08); do_byte(8'h12); do_byte(8'h34); do_stop();
    idle(2);
    check("t4_reg3", 128'(dut_reg(3)), 128'h0000);
    check("t4_no_update", 128'(upd_cnt - base_cnt), 128'd0);

    // 5: async reset mid-transfer, then a clean write
    do_start(); do_byte(8'h84); do_byte(8'h04); do_byte(8'hAB);
    rst_n = 1'b0;
    idle(1);
    check("t5_regs_cleared", 128'(regs), 128'd0);
    check("t5_busy_cleared", 128'(busy), 128'd0);
    rst_n = 1'b1;
    idle(1);
    do_start(); do_byte(8'h84); do_byte(8'h05); do_byte(8'h5A); do_byte(8'hA5); do_stop();
    idle(2);
    check("t5_reg5", 128'(dut_reg(5)), 128'h5AA5);
    check("t5_reg4", 128'(dut_reg(4)), 128'h0000);

    // 6: repeated START across two words
    base_cnt = upd_cnt;
    do_start(); do_byte(8'h84); do_byte(8'h00); do_byte(8'h11);
    check("t6_reg0_before", 128'(dut_reg(0)), 128'h0000);
    do_byte(8'h22);
`ifdef I2C_REG_BANK_SHADOW_EN
    check("t6_reg0_held", 128'(dut_reg(0)), 128'h0000);
`else
    check("t6_reg0_direct", 128'(dut_reg(0)), 128'h1122);
    check("t6_update_direct", 128'(update), 128'd1);
`endif
    do_start(); do_byte(8'h84); do_byte(8'h01); do_byte(8'h33); do_byte(8'h44);
`ifdef I2C_REG_BANK_SHADOW_EN
    check("t6_reg1_held", 128'(dut_reg(1)), 128'h0000);
`endif
    do_stop();
    check("t6_reg0_after_stop", 128'(dut_reg(0)), 128'h1122);
    check("t6_reg1_after_stop", 128'(dut_reg(1)), 128'h3344);
    idle(2);
`ifdef I2C_REG_BANK_SHADOW_EN
    check("t6_update_count", 128'(upd_cnt - base_cnt), 128'd1);
`else
    check("t6_update_count", 128'(upd_cnt - base_cnt), 128'd2);
`endif

    // Back-to-back commits give separate pulses.
    base_cnt = upd_cnt;
    do_start(); do_byte(8'h84); do_byte(8'h02);
    do_byte(8'h01); do_byte(8'h02); do_byte(8'h03); do_byte(8'h04); do_stop();
    idle(2);
`ifdef I2C_REG_BANK_SHADOW_EN
    check("t7_update_count", 128'(upd_cnt - base_cnt), 128'd1);
`else
    check("t7_update_count", 128'(upd_cnt - base_cnt), 128'd2);
`endif
    check("t7_reg3", 128'(dut_reg(3)), 128'h0304);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
